// File: rtl/bnn_xnor_popcount_acc_pkg.sv
// Shared constants and helpers for the binary-network XNOR/popcount datapath.
// Weight and activation encoding throughout: bit 1 means +1, bit 0 means -1.
package bnn_pkg;

  localparam int DEF_WIDTH    = 5;
  localparam int DEF_LENGTH   = 5;
  localparam int DEF_CHANNELS = 4;

  // Smallest r with 2**r >= v; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bnn_xnor_popcount_acc_popcount.sv
// Purely combinational population count of an N-bit vector.
// The result is wide enough for the all-ones case (N).
module bnn_popcount
  import bnn_pkg::*;
#(
  parameter  int N     = DEF_WIDTH * DEF_LENGTH,
  localparam int POP_W = clog2(N + 1)
) (
  input  logic [N-1:0]     bits_in,
  output logic [POP_W-1:0] pop_out
);

  always_comb begin
    pop_out = '0;
    for (int i = 0; i < N; i++) begin
      pop_out = pop_out + POP_W'(bits_in[i]);
    end
  end

endmodule

// File: rtl/bnn_xnor_popcount_acc.sv
// XNOR-popcount of a window against its weights, accumulated over CHANNELS
// valid windows and thresholded into a 1-bit activation.
module bnn_xnor_popcount_acc
  import bnn_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int LENGTH   = DEF_LENGTH,
  parameter  int CHANNELS = DEF_CHANNELS,
  localparam int N        = WIDTH * LENGTH,
  localparam int POP_W    = clog2(N + 1),
  localparam int ACC_W    = clog2(N * CHANNELS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [N-1:0]     window_in,
  input  logic [N-1:0]     weight_in,
  input  logic [ACC_W-1:0] threshold,
  output logic             out_valid,
  output logic             act_out,
  output logic [ACC_W-1:0] acc_out
);

  localparam int CNT_W = (CHANNELS > 1) ? clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHANNELS - 1);

  logic [N-1:0]     xnor_bits;
  logic [POP_W-1:0] pop_comb;

  logic [POP_W-1:0] pop_d, pop_q;
  logic             v1_d, v1_q;
  logic [CNT_W-1:0] ch_cnt_d, ch_cnt_q;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic             out_valid_d, out_valid_q;
  logic             act_d, act_q;
  logic [ACC_W-1:0] acc_out_d, acc_out_q;
  logic [ACC_W-1:0] sum;

  assign xnor_bits = ~(window_in ^ weight_in);

  bnn_popcount #(.N(N)) u_popcount (
    .bits_in (xnor_bits),
    .pop_out (pop_comb)
  );

  always_comb begin
    pop_d       = pop_comb;
    v1_d        = in_valid & ~clear;
    ch_cnt_d    = ch_cnt_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    act_d       = act_q;
    acc_out_d   = acc_out_q;

    // Restarting from zero on the first channel avoids a separate acc reset
    // between activations.
    sum = ((ch_cnt_q == '0) ? '0 : acc_q) + ACC_W'(pop_q);

    if (clear) begin
      ch_cnt_d = '0;
      acc_d    = '0;
    end else if (v1_q) begin
      if (ch_cnt_q == LAST_CNT) begin
        acc_out_d   = sum;
        act_d       = (sum >= threshold);
        out_valid_d = 1'b1;
        ch_cnt_d    = '0;
      end else begin
        acc_d    = sum;
        ch_cnt_d = ch_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_q       <= '0;
      v1_q        <= 1'b0;
      ch_cnt_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      act_q       <= 1'b0;
      acc_out_q   <= '0;
    end else begin
      pop_q       <= pop_d;
      v1_q        <= v1_d;
      ch_cnt_q    <= ch_cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      act_q       <= act_d;
      acc_out_q   <= acc_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign act_out   = act_q;
  assign acc_out   = acc_out_q;

endmodule
